fc_output_stage: RTL and testbench
==================================

FC_OUTPUT_STAGE -- requirements
Module: fc_output_stage

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 23, width of the incoming signed accumulator sum.
REQ-002 SHALL have parameter OUT_WIDTH, default 8, width of each quantized signed result.
REQ-003 SHALL have parameter PACK_NUM, default 4, number of results packed per output word.
REQ-004 SHALL have parameter ADDR_WIDTH, default 10, width of the write address.
REQ-005 SHALL have the following ports:
- clk  in  1  sole clock, rising edge.
- srstn  in  1  reset, asynchronous, active-low.
- acc_in  in  ACC_WIDTH  signed completed MAC sum.
- acc_valid  in  1  acc_in holds a completed sum this cycle.
- acc_last  in  1  qualified by acc_valid; final result of the layer.
- bias_in  in  OUT_WIDTH  signed bias, sampled with acc_valid.
- shift_amt  in  4  right-shift for requantization, sampled with acc_valid.
- out_data  out  PACK_NUM*OUT_WIDTH  packed word; lane 0 in the MSBs.
- out_addr  out  ADDR_WIDTH  word address of out_data.
- out_valid  out  1  out_data/out_addr valid.
- out_ready  in  1  consumer accepts the word when out_valid&&out_ready.
- done  out  1  one-cycle pulse when the last word is accepted.
- overflow  out  1  sticky flag: a word was dropped.

Function
REQ-006 Stage 1 (registered) SHALL compute sum = acc_in + sign-extended bias_in at ACC_WIDTH+1 bits, with no wrap.
REQ-007 Stage 2 (registered) SHALL compute (sum + 2^(shift_amt-1)) >>> shift_amt when shift_amt>0, and sum unchanged when shift_amt=0; the shift is arithmetic.
REQ-008 Stage 2 SHALL saturate the result to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-009 Latency SHALL be 2 cycles from acc_valid to lane write; one result is accepted per cycle with no input backpressure.
REQ-010 The lane counter SHALL start at 0 and write the result into lane (PACK_NUM-1-lane) bit slice, counting from the MSB.
- At lane=PACK_NUM-1, or when the result carries acc_last, the word SHALL move to the output register.
- The lane counter SHALL then return to 0.
REQ-011 A partial word flushed by acc_last SHALL have its unused lanes set to 0.
REQ-012 out_valid SHALL stay high, with out_data/out_addr stable, until out_valid&&out_ready.
REQ-013 out_addr SHALL increment by 1 per accepted word, wrap from 2^ADDR_WIDTH-1 to 0, and return to 0 after done.
REQ-014 If a word completes while out_valid is high and out_ready is low, the new word SHALL be dropped and overflow set; the held word is unaffected.
REQ-015 If a word completes in the same cycle as an accepting handshake, the new word SHALL load with no drop.
REQ-016 done SHALL pulse one cycle after the handshake of the word containing acc_last.
REQ-017 The FSM states SHALL be:
- IDLE: no pending word. Goes to HOLD when a word completes.
- HOLD: out_valid=1. Goes to IDLE on handshake with no new word; stays in HOLD on handshake with a new word; goes to DONE on handshake of the last word.
- DONE: done=1 for one cycle, then IDLE.

Reset
REQ-018 While srstn=0, the following SHALL be 0: out_data, out_addr, out_valid, done, overflow, the lane counter, the pipeline valid bits, and the state (IDLE).
REQ-019 Reset mid-operation SHALL discard all in-flight and partial results; the first acc_valid after release SHALL go to lane 0 at address 0.
REQ-020 overflow SHALL clear only on reset.

Configuration
REQ-021 Macro FC_OUTPUT_RELU_EN SHALL control negative results.
- Defined: stage 2 SHALL clamp negative results to 0, so the range is [0, 2^(OUT_WIDTH-1)-1].
- Undefined: the signed saturation of REQ-008 applies unchanged.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- acc_in=1000, bias=24, shift=4 -> result 64 (0x40) in lane 0, 2 cycles after acc_valid.
- acc_in=-500, bias=0, shift=4 -> 0 with FC_OUTPUT_RELU_EN; -31 (0xE1) without.
- acc_in=100000, bias=0, shift=4 -> saturates to 127 (0x7F).
- results 1,2,3,4 on consecutive cycles, shift=0, out_ready=1 -> out_data=0x01020304, out_addr=0, then results 5,6 with acc_last on 6 -> 0x05060000 at out_addr=1, done pulse, next word at out_addr=0.
- out_ready held 0 through 8 results -> first word held stable, second dropped, overflow=1 and sticky until srstn=0.
- srstn asserted after 2 of 4 lanes are written -> all outputs 0 immediately; the next 4 results produce a full word at out_addr=0.

Source files
------------

// File: rtl/fc_output_stage.sv
// Fully-connected layer output stage: bias add, rounding requantization, saturation and lane packing.
// Optional build macro FC_OUTPUT_RELU_EN clamps negative results to zero.
module fc_output_stage #(
  parameter int ACC_WIDTH  = 23,
  parameter int OUT_WIDTH  = 8,
  parameter int PACK_NUM   = 4,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          srstn,
  input  logic [ACC_WIDTH-1:0]          acc_in,
  input  logic                          acc_valid,
  input  logic                          acc_last,
  input  logic [OUT_WIDTH-1:0]          bias_in,
  input  logic [3:0]                    shift_amt,
  output logic [PACK_NUM*OUT_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]         out_addr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          done,
  output logic                          overflow
);

  localparam int SUM_W  = ACC_WIDTH + 1;
  localparam int RND_W  = SUM_W + 1;
  localparam int LANE_W = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK_NUM - 1);
  localparam logic signed [RND_W-1:0] SAT_MAX =
    {{(RND_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RND_W-1:0] SAT_MIN =
    {{(RND_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DONE} state_t;

  // Round half up, then arithmetic shift; one guard bit keeps the rounding add from wrapping.
  function automatic logic signed [RND_W-1:0] round_shift(input logic signed [SUM_W-1:0] s,
                                                          input logic [3:0] sh);
    logic signed [RND_W-1:0] ext;
    logic signed [RND_W-1:0] half;
    ext  = {s[SUM_W-1], s};
    half = '0;
    if (sh != 4'd0) half = RND_W'(1) << (sh - 4'd1);
    return (ext + half) >>> sh;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [RND_W-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[OUT_WIDTH-1:0];
`ifdef FC_OUTPUT_RELU_EN
    if (v < 0) return '0;
`else
    if (v < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
`endif
    return v[OUT_WIDTH-1:0];
  endfunction

  logic                        vld_p1, vld_p2;
  logic signed [SUM_W-1:0]     sum_p1;
  logic [3:0]                  shift_p1;
  logic                        last_p1, last_p2;
  logic signed [OUT_WIDTH-1:0] res_p2;

  logic [LANE_W-1:0]             lane;
  logic [PACK_NUM*OUT_WIDTH-1:0] word_buf, word_next;
  logic                          out_last;
  logic                          word_done, hs, load;
  state_t                        state, state_next;

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= acc_valid;
      vld_p2 <= vld_p1;
    end
  end

  // Stage 1: bias add at full width
  always_ff @(posedge clk) begin
    sum_p1   <= $signed({acc_in[ACC_WIDTH-1], acc_in})
              + $signed({{(SUM_W-OUT_WIDTH){bias_in[OUT_WIDTH-1]}}, bias_in});
    shift_p1 <= shift_amt;
    last_p1  <= acc_last;
  // Stage 2: requantize and saturate
    res_p2   <= saturate(round_shift(sum_p1, shift_p1));
    last_p2  <= last_p1;
  end

  // Lane packing: writing lane 0 clears the rest so a flushed partial word has zero tail lanes
  assign word_done = vld_p2 && ((lane == LAST_LANE) || last_p2);
  assign hs        = out_valid && out_ready;
  assign load      = word_done && (!out_valid || out_ready);

  always_comb begin
    word_next = (lane == '0) ? '0 : word_buf;
    for (int i = 0; i < PACK_NUM; i++) begin
      if (lane == LANE_W'(i)) word_next[(PACK_NUM-1-i)*OUT_WIDTH +: OUT_WIDTH] = res_p2;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p2) word_buf <= word_next;
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      lane      <= '0;
      out_data  <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
      state     <= S_IDLE;
    end else begin
      state <= state_next;
      if (vld_p2) lane <= word_done ? '0 : lane + LANE_W'(1);
      if (hs) out_addr <= out_last ? '0 : out_addr + ADDR_WIDTH'(1);
      if (load) begin
        out_data  <= word_next;
        out_last  <= last_p2;
        out_valid <= 1'b1;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
      if (word_done && !load) overflow <= 1'b1;
    end
  end

  // Back-to-back last words can hand off while still in DONE, so DONE also watches the handshake.
  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      S_IDLE: if (load) state_next = S_HOLD;
      S_HOLD: begin
        if (hs) begin
          if (out_last)   state_next = S_DONE;
          else if (!load) state_next = S_IDLE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (hs && out_last)                    state_next = S_DONE;
        else if (load || (out_valid && !hs))   state_next = S_HOLD;
        else                                   state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fc_output_stage.sv
// Self-checking bench for fc_output_stage: vector table plus directed packing, overflow and reset sequences.
module tb_fc_output_stage;

  logic        clk;
  logic        srstn;
  logic [22:0] acc_in;
  logic        acc_valid;
  logic        acc_last;
  logic [7:0]  bias_in;
  logic [3:0]  shift_amt;
  logic [31:0] out_data;
  logic [9:0]  out_addr;
  logic        out_valid;
  logic        out_ready;
  logic        done;
  logic        overflow;

  fc_output_stage dut (
    .clk(clk), .srstn(srstn), .acc_in(acc_in), .acc_valid(acc_valid), .acc_last(acc_last),
    .bias_in(bias_in), .shift_amt(shift_amt), .out_data(out_data), .out_addr(out_addr),
    .out_valid(out_valid), .out_ready(out_ready), .done(done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int acc; int bias; int sh; int exp; } vec_t;
  typedef struct { logic [31:0] data; logic [9:0] addr; bit last; } sb_t;

  vec_t vecs[15];
  sb_t  sbq[$];
  int   tests = 0;
  int   failures = 0;
  bit   exp_done = 0;

  function automatic int relu_adj(int e);
`ifdef FC_OUTPUT_RELU_EN
    return (e < 0) ? 0 : e;
`else
    return e;
`endif
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(logic [31:0] d, logic [9:0] a, bit last);
    sb_t it;
    it.data = d; it.addr = a; it.last = last;
    sbq.push_back(it);
  endtask

  task automatic monitor_step();
    sb_t it;
    if (!srstn) begin
      exp_done = 0;
      return;
    end
    if (exp_done || done) chk("done_pulse", 64'(done), 64'(exp_done));
    exp_done = 0;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        tests++; failures++;
        $display("FAIL unexpected_word: got data 0x%0h addr %0d expected none", out_data, out_addr);
      end else begin
        it = sbq.pop_front();
        chk("word_data", 64'(out_data), 64'(it.data));
        chk("word_addr", 64'(out_addr), 64'(it.addr));
        exp_done = it.last;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int a, int b, int sh, bit last);
    acc_valid = 1'b1;
    acc_in    = a[22:0];
    bias_in   = b[7:0];
    shift_amt = sh[3:0];
    acc_last  = last;
    tick();
  endtask

  task automatic idle(int n);
    acc_valid = 1'b0;
    acc_last  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sbq.size() > 0; i++) tick();
    if (sbq.size() != 0) begin
      tests++; failures++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", sbq.size());
      sbq.delete();
    end
    repeat (3) tick();
  endtask

  initial begin
    logic [7:0] e8;
    srstn = 1'b0; acc_valid = 1'b0; acc_last = 1'b0; acc_in = '0;
    bias_in = '0; shift_amt = '0; out_ready = 1'b1;

    vecs[0]  = '{1000, 24, 4, 64};
    vecs[1]  = '{-500, 0, 4, -31};
    vecs[2]  = '{100000, 0, 4, 127};
    vecs[3]  = '{-100000, 0, 4, -128};
    vecs[4]  = '{5, -3, 0, 2};
    vecs[5]  = '{7, 0, 1, 4};
    vecs[6]  = '{-7, 0, 1, -3};
    vecs[7]  = '{127, 0, 0, 127};
    vecs[8]  = '{128, 0, 0, 127};
    vecs[9]  = '{-128, 0, 0, -128};
    vecs[10] = '{-129, 0, 0, -128};
    vecs[11] = '{4194303, 127, 15, 127};
    vecs[12] = '{-4194304, -128, 15, -128};
    vecs[13] = '{23, 0, 3, 3};
    vecs[14] = '{-24, 0, 3, -3};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_addr", 64'(out_addr), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);
    srstn = 1'b1;
    tick();

    // Two-cycle latency on the first result
    send(1000, 24, 4, 1'b1);
    push(32'h4000_0000, 10'd0, 1'b1);
    acc_valid = 1'b0; acc_last = 1'b0;
    tick();
    chk("lat_not_yet", 64'(out_valid), 64'h0);
    tick();
    chk("lat_valid", 64'(out_valid), 64'h1);
    chk("lat_data", 64'(out_data), 64'h4000_0000);
    drain();

    // Vector table: each result flushed alone as a last word
    for (int i = 0; i < 15; i++) begin
      e8 = 8'(relu_adj(vecs[i].exp));
      send(vecs[i].acc, vecs[i].bias, vecs[i].sh, 1'b1);
      push({e8, 24'h0}, 10'd0, 1'b1);
    end
    idle(1);
    drain();

    // Full word, partial last word, then address restart
    for (int i = 1; i <= 4; i++) send(i, 0, 0, 1'b0);
    push(32'h0102_0304, 10'd0, 1'b0);
    send(5, 0, 0, 1'b0);
    send(6, 0, 0, 1'b1);
    push(32'h0506_0000, 10'd1, 1'b1);
    idle(1);
    drain();
    for (int i = 7; i <= 10; i++) send(i, 0, 0, 1'b0);
    push(32'h0708_090A, 10'd0, 1'b0);
    idle(1);
    drain();

    // Consumer stalled across two words
    out_ready = 1'b0;
    for (int i = 'h11; i <= 'h18; i++) send(i, 0, 0, 1'b0);
    push(32'h1112_1314, 10'd1, 1'b0);
    idle(4);
    chk("ovf_set", 64'(overflow), 64'h1);
    chk("ovf_hold_valid", 64'(out_valid), 64'h1);
    chk("ovf_hold_data", 64'(out_data), 64'h1112_1314);
    chk("ovf_hold_addr", 64'(out_addr), 64'd1);
    idle(3);
    chk("ovf_hold_data2", 64'(out_data), 64'h1112_1314);
    out_ready = 1'b1;
    drain();
    for (int i = 'h21; i <= 'h24; i++) send(i, 0, 0, 1'b0);
    push(32'h2122_2324, 10'd2, 1'b0);
    idle(1);
    drain();
    chk("ovf_sticky", 64'(overflow), 64'h1);

    // Reset with a half-filled word in the buffer
    send('h31, 0, 0, 1'b0);
    send('h32, 0, 0, 1'b0);
    idle(3);
    #2;
    srstn = 1'b0;
    #1;
    chk("mid_rst_data", 64'(out_data), 64'h0);
    chk("mid_rst_addr", 64'(out_addr), 64'h0);
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_overflow", 64'(overflow), 64'h0);
    chk("mid_rst_done", 64'(done), 64'h0);
    tick();
    srstn = 1'b1;
    tick();
    for (int i = 'h41; i <= 'h44; i++) send(i, 0, 0, 1'b0);
    push(32'h4142_4344, 10'd0, 1'b0);
    idle(1);
    drain();
    chk("post_rst_overflow", 64'(overflow), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
